// File: rtl/uart_pkg.sv
// Shared definitions for the asynchronous serial link (transmitter and receiver).
package uart_pkg;

  // Transmitter frame sequencer states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Line levels common to both ends of the link
  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle bit_tick on the last cycle of each serial bit.
// clr holds the count at zero so a new frame always starts a full bit period.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_tick = (cnt == LAST) && !clr;

  // Count 0..CLKS_PER_BIT-1, wrapping on every bit boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (clr || bit_tick) cnt <= '0;
    else                      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_transmitter.sv
// Serial transmitter: one byte per valid/ready handshake, framed as
// start, data LSB-first, optional parity, stop bit(s). Line idles high.
// tx is registered from the current state, so the line lags the state by one
// cycle; busy follows the state directly.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       LAST_STOP = (STOP_BITS == 2);
  localparam logic       PAR_INV   = (PARITY_ODD != 0);
  localparam logic       HAS_PAR   = (PARITY_EN != 0);

  state_t               state, state_n;
  logic [DATA_BITS-1:0] shreg;
  logic [2:0]           bitcnt;
  logic                 stopcnt;
  logic                 par;
  logic                 tx_n;
  logic                 bit_tick;
  logic                 hs;

  assign hs   = tx_valid && tx_ready;
  assign busy = (state != IDLE);

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == IDLE),
    .bit_tick (bit_tick)
  );

  // State, line and ready registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx       <= LINE_IDLE;
      tx_ready <= 1'b1;
    end else begin
      state    <= state_n;
      tx       <= tx_n;
      tx_ready <= (state_n == IDLE);
    end
  end

  // Next state and line level for the current bit
  always_comb begin
    state_n = state;
    tx_n    = LINE_IDLE;
    case (state)
      IDLE: begin
        if (hs) state_n = START;
      end
      START: begin
        tx_n = START_LEVEL;
        if (bit_tick) state_n = DATA;
      end
      DATA: begin
        tx_n = shreg[0];
        if (bit_tick && bitcnt == LAST_BIT) state_n = HAS_PAR ? PARITY : STOP;
      end
      PARITY: begin
        tx_n = par;
        if (bit_tick) state_n = STOP;
      end
      STOP: begin
        tx_n = STOP_LEVEL;
        if (bit_tick && stopcnt == LAST_STOP) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift register, bit/stop counters and parity, loaded on the handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
      par     <= 1'b0;
    end else if (hs) begin
      shreg   <= tx_data;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
      par     <= (^tx_data) ^ PAR_INV;
    end else if (bit_tick) begin
      if (state == DATA) begin
        shreg  <= shreg >> 1;
        bitcnt <= bitcnt + 1'b1;
      end
      if (state == STOP) stopcnt <= stopcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four configurations at CLKS_PER_BIT=4.
//   sel 0: 8 data, even parity, 1 stop    sel 1: 8 data, odd parity, 1 stop
//   sel 2: 8 data, no parity, 2 stop      sel 3: 5 data, even parity, 1 stop
// Each trace entry is sampled 1 time unit after a rising edge; entry 0 is
// the cycle right after the handshake edge. Line bit k sits at entry 3+4k.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] td = 8'h00;
  logic [3:0] vld = 4'b0;
  logic [3:0] txs, bsy, rdy;

  always #5 clk = ~clk;

  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .tx_data(td), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txs[0]), .busy(bsy[0]));
  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst_n(rst_n), .tx_data(td), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txs[1]), .busy(bsy[1]));
  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_n (
    .clk(clk), .rst_n(rst_n), .tx_data(td), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txs[2]), .busy(bsy[2]));
  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_5 (
    .clk(clk), .rst_n(rst_n), .tx_data(td[4:0]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx(txs[3]), .busy(bsy[3]));

  typedef struct {
    int          sel;
    logic [7:0]  d;
    int          nb;    // line bits per frame
    logic [10:0] bits;  // expected frame, bit 0 = start bit
    int          blen;  // expected busy cycles
  } vec_t;

  vec_t vt[8];
  int   ncmp = 0;
  int   nerr = 0;
  int   sel  = 0;
  logic tr_tx[100], tr_busy[100], tr_rdy[100];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // Present a byte to instance s; returns 1 time unit after the handshake edge
  task automatic start(input int s, input logic [7:0] d);
    @(negedge clk);
    td     = d;
    vld[s] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Record n cycles; tx_data switches to next_d at entry 0, valid drops at
  // entry keep_until, and a stray valid pulse with 0xFF at pulse_at (if >=0)
  task automatic capture(input int n, input int keep_until, input int pulse_at,
                         input logic [7:0] next_d);
    for (int c = 0; c < n; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      tr_tx[c]   = txs[sel];
      tr_busy[c] = bsy[sel];
      tr_rdy[c]  = rdy[sel];
      if (c == 0) td = next_d;
      if (c == keep_until) vld[sel] = 1'b0;
      if (c == pulse_at) begin
        td       = 8'hFF;
        vld[sel] = 1'b1;
      end
      if (pulse_at >= 0 && c == pulse_at + 1) vld[sel] = 1'b0;
    end
  endtask

  function automatic logic [10:0] bits_at(input int base, input int nb);
    logic [10:0] r = '0;
    for (int k = 0; k < nb; k++) r[k] = tr_tx[base + 3 + 4*k];
    return r;
  endfunction

  function automatic int busy_run(input int base);
    int n = 0;
    while (base + n < 100 && tr_busy[base + n] === 1'b1) n++;
    return n;
  endfunction

  function automatic int ones_rdy(input int first, input int last);
    int n = 0;
    for (int c = first; c <= last; c++) if (tr_rdy[c] !== 1'b0) n++;
    return n;
  endfunction

  initial begin
    // {stop(s), parity, data MSB..LSB, start}
    vt[0] = '{0, 8'hA5, 11, 11'b1_0_10100101_0, 44};
    vt[1] = '{1, 8'hA5, 11, 11'b1_1_10100101_0, 44};
    vt[2] = '{0, 8'h00, 11, 11'b1_0_00000000_0, 44};
    vt[3] = '{2, 8'h3C, 11, 11'b1_1_00111100_0, 44};
    vt[4] = '{0, 8'hFF, 11, 11'b1_0_11111111_0, 44};
    vt[5] = '{0, 8'h07, 11, 11'b1_1_00000111_0, 44};
    vt[6] = '{1, 8'h01, 11, 11'b1_0_00000001_0, 44};
    vt[7] = '{3, 8'hE3,  8, 11'b000_1_0_00011_0, 32};

    // Reset state
    #12;
    chk("reset_tx",    txs, 4'hF);
    chk("reset_ready", rdy, 4'hF);
    chk("reset_busy",  bsy, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames across configurations
    foreach (vt[i]) begin
      sel = vt[i].sel;
      start(sel, vt[i].d);
      capture(50, 0, -1, ~vt[i].d);
      chk($sformatf("v%0d_bits", i), bits_at(0, vt[i].nb), vt[i].bits);
      chk($sformatf("v%0d_busy_len", i), busy_run(0), vt[i].blen);
      chk($sformatf("v%0d_ready_drop", i), tr_rdy[0], 1'b0);
      chk($sformatf("v%0d_ready_back", i), tr_rdy[vt[i].blen], 1'b1);
      chk($sformatf("v%0d_tx_pre", i), tr_tx[0], 1'b1);
    end

    // Back-to-back with valid held: exactly one idle cycle between frames
    sel = 0;
    start(0, 8'h55);
    capture(100, 45, -1, 8'h0F);
    chk("b2b_f1_bits", bits_at(0, 11), 11'b1_0_01010101_0);
    chk("b2b_f1_busy", busy_run(0), 44);
    chk("b2b_gap_busy", tr_busy[44], 1'b0);
    chk("b2b_gap_tx", tr_tx[44], 1'b1);
    chk("b2b_f2_busy", busy_run(45), 44);
    chk("b2b_f2_bits", bits_at(45, 11), 11'b1_0_00001111_0);

    // Stray valid mid-frame is ignored
    start(0, 8'h5A);
    capture(50, 0, 10, 8'h33);
    chk("midv_bits", bits_at(0, 11), 11'b1_0_01011010_0);
    chk("midv_busy", busy_run(0), 44);
    chk("midv_ready_low", ones_rdy(0, 43), 0);

    // Reset during data bit 3, then a clean frame
    start(0, 8'hA5);
    vld[0] = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    chk("rst_mid_busy_pre", bsy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tx",    txs[0], 1'b1);
    chk("rst_mid_ready", rdy[0], 1'b1);
    chk("rst_mid_busy",  bsy[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_no_resume", {txs[0], bsy[0]}, 2'b10);
    start(0, 8'hC3);
    capture(50, 0, -1, 8'h00);
    chk("rst_after_bits", bits_at(0, 11), 11'b1_0_11000011_0);
    chk("rst_after_busy", busy_run(0), 44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
